iter_mult: RTL
==============

Name: iter_mult

Overview:
- Parametrised iterative multiplier/squarer; successor to the single-mode squarer.
- Multiplies two WIDTH-bit unsigned operands, or squares one, by shift-add over BITS_PER_CYCLE multiplier bits per clock.
- Used by the modular-arithmetic datapath wherever a full 2*WIDTH-bit product is needed with a busy/valid handshake and bounded area.

Parameters:
- WIDTH, 16, operand width in bits.
- BITS_PER_CYCLE, 1, multiplier bits consumed per RUN cycle. Must divide WIDTH exactly; otherwise elaboration fails with a fatal assertion.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- ready_in  input  1  start request; sampled only in IDLE.
- mode_in  input  1  0 = multiply a_in*b_in; 1 = square a_in (b_in ignored). Sampled with ready_in.
- a_in  input  WIDTH  multiplicand / value to square.
- b_in  input  WIDTH  multiplier (multiply mode only).
- product_out  output  2*WIDTH  result; registered; held until next completion.
- busy_out  output  1  high while an operation is in RUN.
- valid_out  output  1  one-cycle pulse; product_out is new and valid this cycle.

Behaviour:
- N = WIDTH/BITS_PER_CYCLE.
- States: IDLE, RUN, DONE.
- Reset (rst_in high at an edge):
  - state=IDLE; product_out=0; busy_out=0; valid_out=0.
  - Accumulator, counter and operand registers cleared.
  - Reset takes priority over all other activity, including mid-RUN; the partial product is discarded and no valid_out is produced.
- IDLE:
  - On an edge with ready_in=1, latch opA=a_in and opB=(mode_in ? a_in : b_in); clear accumulator; counter=0; go to RUN; busy_out=1.
  - Otherwise stay in IDLE.
- RUN: each edge, using chunk k = opB[k*BPC +: BPC] (k = counter):
  - acc += (opA * chunk) << (k*BPC); arithmetic is 2*WIDTH bits wide and never overflows.
  - counter increments each edge.
  - On the edge processing chunk N-1: product_out <= final acc; state=DONE; busy_out=0; valid_out=1.
- DONE: valid_out=1 for exactly this cycle; next edge goes to IDLE with valid_out=0. ready_in is ignored in DONE.
- Latency: with the accept edge as E0, valid_out is high between edges EN and EN+1.
- Throughput: with ready_in held high, the next accept occurs at edge EN+2, one operation per N+2 cycles.
- busy_out and valid_out are never high together. busy_out is high for exactly N cycles per operation.
- ready_in, mode_in, a_in and b_in may change freely after the accept edge; the in-flight operation uses the latched values.
- product_out changes only on the completing edge or on reset.
- Zero operands follow the normal path with full latency; there is no early termination.

Test Plan:
- WIDTH=16, BPC=1, mode=1, a=0xFFFF, single ready pulse -> busy_out high 16 cycles; valid_out one pulse 16 cycles after accept; product_out=0xFFFE0001.
- WIDTH=16, BPC=1, mode=0, a=1234, b=5678; a_in/b_in randomised every cycle after accept -> product_out=0x006AE9BC (7006652), unaffected by input changes.
- WIDTH=8, BPC=4, mode=1, a=200 -> valid_out 2 cycles after accept; product_out=0x9C40; busy_out high 2 cycles.
- WIDTH=16, BPC=1, ready_in held high, a=3 then 5 (mode=1) -> products 9 and 25; accepts 18 cycles apart; exactly one valid_out per product.
- Start a=0xFFFF square, assert rst_in at RUN cycle 7 -> next cycle: IDLE, busy_out=0, product_out=0, no valid_out. A fresh multiply a=0, b=0xABCD then yields 0 with full 16-cycle latency.
- WIDTH=12, BPC=5 -> elaboration fails with a fatal assertion.

Source files
------------

// File: rtl/iter_mult.sv
`default_nettype none
// ============================================================================
//  Module      : iter_mult
//  Description : Iterative unsigned multiplier / squarer. Consumes
//                BITS_PER_CYCLE multiplier bits per clock by shift-add and
//                returns the full 2*WIDTH-bit product with a busy/valid
//                handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_mult #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 ready_in,
    input  logic                 mode_in,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic [2*WIDTH-1:0]   product_out,
    output logic                 busy_out,
    output logic                 valid_out
);

    localparam int c_num_chunks = WIDTH / BITS_PER_CYCLE;
    localparam int c_cnt_w      = (c_num_chunks > 1) ? $clog2(c_num_chunks) : 1;
    localparam logic [c_cnt_w-1:0] c_last_chunk = c_cnt_w'(c_num_chunks - 1);

    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_run  = 2'd1;
    localparam logic [1:0] c_s_done = 2'd2;

    generate
        if ((BITS_PER_CYCLE < 1) || (BITS_PER_CYCLE > WIDTH) ||
            ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_bits_per_cycle
            $fatal(1, "iter_mult: BITS_PER_CYCLE must divide WIDTH exactly");
        end
    endgenerate

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic [c_cnt_w-1:0]        r_cnt;
    // Multiplicand pre-shifted by k*BITS_PER_CYCLE, multiplier shifted down so
    // the current chunk always sits in the low bits.
    logic [2*WIDTH-1:0]        r_mcand;
    logic [WIDTH-1:0]          r_mplier;
    logic [2*WIDTH-1:0]        r_acc;

    logic [BITS_PER_CYCLE-1:0] w_chunk;
    logic [2*WIDTH-1:0]        w_partial;
    logic [2*WIDTH-1:0]        w_acc_next;
    logic                      w_last;

    assign w_chunk    = r_mplier[BITS_PER_CYCLE-1:0];
    assign w_partial  = r_mcand * {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, w_chunk};
    assign w_acc_next = r_acc + w_partial;
    assign w_last     = (r_cnt == c_last_chunk);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_s_idle: if (ready_in) w_state_next = c_s_run;
            c_s_run:  if (w_last)   w_state_next = c_s_done;
            c_s_done: w_state_next = c_s_idle;
            default:  w_state_next = c_s_idle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= c_s_idle;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            product_out <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                c_s_idle: begin
                    if (ready_in) begin
                        r_mcand  <= {{WIDTH{1'b0}}, a_in};
                        r_mplier <= mode_in ? a_in : b_in;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                c_s_run: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << BITS_PER_CYCLE;
                    r_mplier <= r_mplier >> BITS_PER_CYCLE;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) product_out <= w_acc_next;
                end
                default: ;
            endcase
        end
    end

    assign busy_out  = (r_state == c_s_run);
    assign valid_out = (r_state == c_s_done);

endmodule
`default_nettype wire
